// File: rtl/alu_issuer_pkg.sv
// Shared definitions for the ALU command issuer.
// Holds the opcode map, the issuer FSM state encoding, the ALU operand and result widths,
// and the packed command word that is stored in the command FIFO.
package alu_issuer_pkg;

    localparam int unsigned OPND_W = 4;                      // ALU operand width
    localparam int unsigned RES_W  = 5;                      // ALU result width
    localparam int unsigned OP_W   = 3;                      // opcode width
    localparam int unsigned CMD_W  = 2 * OPND_W + OP_W + 1;  // a, b, op, chain

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_NOT = 3'b101;
    localparam logic [OP_W-1:0] OP_SHL = 3'b110;
    localparam logic [OP_W-1:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRIVE    = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

    // One queued command. When chain is set, a is replaced by the previous result.
    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic [OP_W-1:0]   op;
        logic              chain;
    } cmd_t;

endpackage

// File: rtl/alu_issuer_if.sv
// Bundle of the command, ALU and response signals of the issuer.
//   cmd_*  : command offer (valid/ready) with operands, opcode and chain flag
//   alu_*  : registered operands/opcode to an external combinational ALU, and its result
//   rsp_*  : held response (valid/ready) with captured result and opcode
// slave  : the issuer side.
// master : the environment side (command source, ALU, response sink).
interface alu_issuer_if;
    import alu_issuer_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OPND_W-1:0] cmd_a;
    logic [OPND_W-1:0] cmd_b;
    logic [OP_W-1:0]   cmd_op;
    logic              cmd_chain;

    logic [OPND_W-1:0] alu_a;
    logic [OPND_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [RES_W-1:0]  alu_result;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [RES_W-1:0]  rsp_data;
    logic [OP_W-1:0]   rsp_op;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain,
        output cmd_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result,
        output rsp_valid, rsp_data, rsp_op,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result,
        input  rsp_valid, rsp_data, rsp_op,
        output rsp_ready
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU issuer: DEPTH entries of WIDTH bits, power-of-two depth.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data when not full (ignored when full)
//   push_data   : entry to write
//   pop         : drop the head entry when not empty (ignored when empty)
//   head_c      : current head entry (read straight from storage)
//   empty       : registered, FIFO holds no entries
//   not_full    : registered, FIFO can accept an entry
module alu_cmd_fifo
    import alu_issuer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = CMD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_c,
    output logic             empty,
    output logic             not_full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    logic             not_full_q, not_full_d;

    logic             do_push_c;
    logic             do_pop_c;

    assign do_push_c = push && not_full_q;
    assign do_pop_c  = pop && !empty_q;

    // Pointers wrap naturally since DEPTH is a power of two; flags track the next count.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        empty_d    = empty_q;
        not_full_d = not_full_q;

        if (do_push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d    = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        empty_d    = (count_d == CNT_W'(0));
        not_full_d = (count_d < CNT_W'(DEPTH));
    end

    // Control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            not_full_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            not_full_q <= not_full_d;
        end
    end

    // Storage needs no reset: entries are only read once counted as valid.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_c   = mem_q[rd_ptr_q];
    assign empty    = empty_q;
    assign not_full = not_full_q;

endmodule

// File: rtl/alu_issuer.sv
// ALU command issuer.
// Queues commands in a FIFO, drives one command at a time to an external combinational
// ALU for one cycle, captures the result into a held response, and optionally chains the
// previous result into operand a of the next command.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_issuer_if.slave (cmd_*, alu_*, rsp_* groups)
// Parameter DEPTH: command FIFO entries, power of two, at least 2.
module alu_issuer
    import alu_issuer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_issuer_if.slave bus
);

    cmd_t              push_cmd_c;
    logic [CMD_W-1:0]  fifo_head_c;
    cmd_t              head_c;
    logic              fifo_empty;
    logic              fifo_not_full;
    logic              fifo_pop_c;
    logic [OPND_W-1:0] load_a_c;

    state_e            state_q, state_d;
    logic [OPND_W-1:0] alu_a_q, alu_a_d;
    logic [OPND_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [RES_W-1:0]  rsp_data_q, rsp_data_d;
    logic [OP_W-1:0]   rsp_op_q, rsp_op_d;
    // Only the operand-width slice of the last result is ever chained, so only that is kept.
    logic [OPND_W-1:0] last_result_q, last_result_d;

    assign push_cmd_c = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op, chain: bus.cmd_chain};

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.cmd_valid),
        .push_data (push_cmd_c),
        .pop       (fifo_pop_c),
        .head_c    (fifo_head_c),
        .empty     (fifo_empty),
        .not_full  (fifo_not_full)
    );

    assign head_c   = cmd_t'(fifo_head_c);
    assign load_a_c = head_c.chain ? last_result_q : head_c.a;

    // Next-state and datapath: pop into the ALU regs, hold for DRIVE, capture, then wait.
    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_op_d      = rsp_op_q;
        last_result_d = last_result_q;
        fifo_pop_c    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop_c = 1'b1;
                    alu_a_d    = load_a_c;
                    alu_b_d    = head_c.b;
                    alu_op_d   = head_c.op;
                    state_d    = DRIVE;
                end
            end
            DRIVE: begin
                rsp_data_d    = bus.alu_result;
                rsp_op_d      = alu_op_q;
                last_result_d = bus.alu_result[OPND_W-1:0];
                rsp_valid_d   = 1'b1;
                state_d       = WAIT_RSP;
            end
            WAIT_RSP: begin
                // rsp_valid is always high here, so rsp_ready alone completes the handshake.
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop_c = 1'b1;
                        alu_a_d    = load_a_c;
                        alu_b_d    = head_c.b;
                        alu_op_d   = head_c.op;
                        state_d    = DRIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_op_q      <= '0;
            last_result_q <= '0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_op_q      <= rsp_op_d;
            last_result_q <= last_result_d;
        end
    end

    assign bus.cmd_ready = fifo_not_full;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_op    = rsp_op_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Testbench for alu_issuer: directed commands, expected responses queued at issue time
// and compared by an independent response monitor.
module tb_alu_issuer;
    import alu_issuer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_issuer_if bus();

    alu_issuer #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External combinational ALU.
    always_comb begin
        bus.alu_result = '0;
        case (bus.alu_op)
            OP_ADD: bus.alu_result = 5'(bus.alu_a) + 5'(bus.alu_b);
            OP_SUB: bus.alu_result = 5'(bus.alu_a) - 5'(bus.alu_b);
            OP_AND: bus.alu_result = {1'b0, bus.alu_a & bus.alu_b};
            OP_OR:  bus.alu_result = {1'b0, bus.alu_a | bus.alu_b};
            OP_XOR: bus.alu_result = {1'b0, bus.alu_a ^ bus.alu_b};
            OP_NOT: bus.alu_result = {1'b0, ~bus.alu_a};
            OP_SHL: bus.alu_result = {bus.alu_a, 1'b0};
            OP_SHR: bus.alu_result = {2'b00, bus.alu_a[3:1]};
            default: bus.alu_result = '0;
        endcase
    end

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct packed {
        logic [4:0] data;
        logic [2:0] op;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Response monitor: every completed handshake must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_rsp: got data %0d op %0d, required no response (t=%0t)",
                         bus.rsp_data, bus.rsp_op, $time);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                check("rsp_op", 32'(bus.rsp_op), 32'(e.op));
            end
        end
    end

    // Offer one command; returns 1ns after the accepting edge.
    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic chain, input logic expect_rsp, input logic [4:0] exp_data);
        int waited = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        bus.cmd_chain = chain;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            n_checks++;
            n_fails++;
            $display("FAIL push_timeout: cmd_ready got %b, required 1 within 60 cycles", bus.cmd_ready);
            bus.cmd_valid = 1'b0;
            return;
        end
        if (expect_rsp) exp_q.push_back({exp_data, op});
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Wait for all expected responses; returns 1ns after a rising edge.
    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL %s_drain: got %0d responses outstanding, required 0", name, exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required end before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_op    = '0;
        bus.cmd_chain = 1'b0;
        bus.rsp_ready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_alu_a", 32'(bus.alu_a), 32'd0);
        check("rst_alu_b", 32'(bus.alu_b), 32'd0);
        check("rst_alu_op", 32'(bus.alu_op), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_rsp_op", 32'(bus.rsp_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Chain as first command after reset: a taken as 0, not 0 = 01111.
        push(4'd5, 4'd0, OP_NOT, 1'b1, 1'b1, 5'b01111);
        @(posedge clk);
        #1;
        check("chain0_alu_a", 32'(bus.alu_a), 32'd0);
        check("chain0_alu_op", 32'(bus.alu_op), 32'(OP_NOT));
        drain("chain0");

        // add 9+8 = 17, valid after the second edge following the push.
        push(4'd9, 4'd8, OP_ADD, 1'b0, 1'b1, 5'd17);
        @(negedge clk);
        check("lat_valid_n0", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check("lat_valid_n1", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check("lat_valid_n2", 32'(bus.rsp_valid), 32'd1);
        check("lat_data_n2", 32'(bus.rsp_data), 32'd17);
        drain("add");

        // Remaining opcodes, back to back.
        push(4'd3,  4'd5,  OP_SUB, 1'b0, 1'b1, 5'd30);
        push(4'd15, 4'd0,  OP_SHL, 1'b0, 1'b1, 5'd30);
        push(4'd12, 4'd10, OP_AND, 1'b0, 1'b1, 5'd8);
        push(4'd12, 4'd3,  OP_OR,  1'b0, 1'b1, 5'd15);
        push(4'd15, 4'd5,  OP_XOR, 1'b0, 1'b1, 5'd10);
        push(4'd9,  4'd0,  OP_SHR, 1'b0, 1'b1, 5'd4);
        drain("ops");

        // Chaining: 4+3 = 7, then shl of chained 7 = 14.
        push(4'd4, 4'd3, OP_ADD, 1'b0, 1'b1, 5'd7);
        push(4'd0, 4'd0, OP_SHL, 1'b1, 1'b1, 5'd14);
        drain("chain");

        // Backpressure: 5 commands, 1 held in response, 4 queued.
        bus.rsp_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push(4'(i), 4'd2, OP_ADD, 1'b0, 1'b1, 5'(i + 2));
        end
        @(negedge clk);
        check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_rsp_data", 32'(bus.rsp_data), 32'd3);
            check("hold_rsp_op", 32'(bus.rsp_op), 32'(OP_ADD));
            check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check("hold_alu_a", 32'(bus.alu_a), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_first_pop_ready", 32'(bus.cmd_ready), 32'd1);
        drain("bp");

        // Reset while in DRIVE with 3 commands queued.
        bus.rsp_ready = 1'b0;
        push(4'd1, 4'd1, OP_ADD, 1'b0, 1'b1, 5'd2);
        push(4'd2, 4'd2, OP_ADD, 1'b0, 1'b0, 5'd0);
        push(4'd3, 4'd3, OP_ADD, 1'b0, 1'b0, 5'd0);
        push(4'd4, 4'd4, OP_ADD, 1'b0, 1'b0, 5'd0);
        bus.rsp_ready = 1'b1;
        push(4'd5, 4'd5, OP_ADD, 1'b0, 1'b0, 5'd0);
        check("pre_rst_alu_a", 32'(bus.alu_a), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("mid_rst_alu_a", 32'(bus.alu_a), 32'd0);
        check("mid_rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_outstanding", 32'(exp_q.size()), 32'd0);
        check("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  command FIFO not full.
REQ-006 SHALL have port cmd_a  input  4  operand a.
REQ-007 SHALL have port cmd_b  input  4  operand b.
REQ-008 SHALL have port cmd_op  input  3  opcode.
REQ-009 SHALL have port cmd_chain  input  1  replace a with the low 4 bits of the previous result.
REQ-010 SHALL have port alu_a  output  4  registered operand a to the ALU.
REQ-011 SHALL have port alu_b  output  4  registered operand b to the ALU.
REQ-012 SHALL have port alu_op  output  3  registered opcode to the ALU.
REQ-013 SHALL have port alu_result  input  5  combinational ALU result.
REQ-014 SHALL have port rsp_valid  output  1  response held.
REQ-015 SHALL have port rsp_ready  input  1  response consumer ready.
REQ-016 SHALL have port rsp_data  output  5  captured result.
REQ-017 SHALL have port rsp_op  output  3  opcode that produced rsp_data.

Function
REQ-018 Opcode map SHALL be: 000 add, 001 sub (mod 32), 010 and, 011 or, 100 xor, 101 not a, 110 a<<1, 111 a>>1, with the 5-bit result zero-extended.
REQ-019 A command SHALL be pushed on the edge where cmd_valid && cmd_ready; cmd_ready SHALL equal (count < DEPTH), independent of cmd_valid.
REQ-020 The FSM SHALL have states IDLE, DRIVE and WAIT_RSP.
REQ-021 In IDLE with FIFO non-empty, the head SHALL be popped into alu_a/alu_b/alu_op and the state SHALL go to DRIVE; IDLE with FIFO empty SHALL hold.
REQ-022 DRIVE SHALL last exactly one cycle; at its end, alu_result SHALL be captured into rsp_data and last_result, alu_op into rsp_op, rsp_valid SHALL be set, and the state SHALL go to WAIT_RSP.
REQ-023 In WAIT_RSP, rsp_valid, rsp_data and rsp_op SHALL hold stable until rsp_ready.
REQ-024 On the rsp_valid && rsp_ready edge, rsp_valid SHALL clear; if the FIFO is non-empty, the next head SHALL pop on that same edge and the state SHALL go to DRIVE, else it SHALL go to IDLE.
REQ-025 Latency SHALL be: command pushed at edge N into an empty FIFO in IDLE gives rsp_valid high after edge N+2; sustained throughput SHALL be one response per 2 cycles with rsp_ready held high.
REQ-026 For cmd_chain=1, alu_a SHALL be last_result[3:0] sampled at pop time, cmd_a SHALL be ignored, and last_result SHALL be 0 if no result has been captured since reset.
REQ-027 A push and a pop on the same edge SHALL leave count unchanged; pop SHALL never occur when empty; the pointers SHALL wrap modulo DEPTH.
REQ-028 alu_a/alu_b/alu_op SHALL hold their last driven values outside DRIVE.

Reset
REQ-029 On rst_n low, FIFO count and pointers, last_result, alu_a, alu_b, alu_op, rsp_data and rsp_op SHALL all become 0, rsp_valid SHALL become 0, and the state SHALL become IDLE, immediately and without a clock edge.
REQ-030 Reset mid-operation SHALL discard queued and in-flight commands without producing a response; cmd_ready SHALL read 1 during and after reset.

Structure
REQ-031 A shared package SHALL hold the opcode constants (OP_ADD..OP_SHR), the FSM state encoding, and the ALU operand/result widths (4/5).
REQ-032 The FIFO SHALL be one sub-module, alu_cmd_fifo (width 12 = a,b,op,chain; DEPTH entries), and the FSM and datapath SHALL stay in alu_issuer.

Verification
REQ-033 Directed test SHALL cover: add a=9 b=8, rsp_ready=1 -> rsp_data=5'b10001 (17) two cycles after push.
REQ-034 Directed test SHALL cover: sub a=3 b=5 -> rsp_data=5'b11110 (30); shl a=15 -> 5'b11110.
REQ-035 Directed test SHALL cover: add 4+3, then shl with cmd_chain=1 and cmd_a=0 -> responses 7 then 14; chain as the first command after reset with op not -> alu_a=0, result 5'b01111.
REQ-036 Directed test SHALL cover: rsp_ready=0, push 5 commands -> 1 in WAIT_RSP, FIFO holds 4, cmd_ready=0; release rsp_ready -> 5 responses in order, cmd_ready returns 1 on the first pop.
REQ-037 Directed test SHALL cover: rsp_ready held low for 10 cycles -> rsp_data/rsp_op stable, no FIFO pop.
REQ-038 Directed test SHALL cover: rst_n low during DRIVE with 3 queued -> rsp_valid=0 and cmd_ready=1 immediately, with no responses after release.
